// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe : two-stage pipelined signed ALU with valid/ready on both sides.
//   S1 holds the accepted operands, S2 holds the computed result and overflow.
//   The stall chain has no bubbles: S2 may pop and refill in the same cycle.
//   ops_done counts output handshakes and wraps at 2^CNT_W.
// Configuration:
//   ALU_SAT_EN defined   : overflowing results clamp to the signed min/max.
//   ALU_SAT_EN undefined : result is the low WIDTH bits (wrap-around).
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic [CNT_W-1:0] ops_done
);

    // Three guard bits hold every opcode's exact result (worst case a+3*b).
    localparam int XW = WIDTH + 3;

    localparam logic [2:0] OP_SHL_ADD = 3'b000;
    localparam logic [2:0] OP_A_3B    = 3'b001;
    localparam logic [2:0] OP_NEG_B   = 3'b010;
    localparam logic [2:0] OP_ABS_A   = 3'b011;
    localparam logic [2:0] OP_SUB     = 3'b100;
    localparam logic [2:0] OP_AND     = 3'b101;
    localparam logic [2:0] OP_OR      = 3'b110;
    localparam logic [2:0] OP_XOR     = 3'b111;

    // Stage S1: captured operands
    logic             s1_v;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;

    // Stage S2: registered result
    logic             s2_v;
    logic [WIDTH-1:0] s2_result;
    logic             s2_ovf;
    logic [CNT_W-1:0] cnt;

    // Handshake control
    logic s2_adv;
    logic take_in;
    logic pop;

    // Datapath
    logic signed [XW-1:0] ext_a;
    logic signed [XW-1:0] ext_b;
    logic signed [XW-1:0] full;
    logic                 is_logic;
    logic                 fits;
    logic                 calc_ovf;
    logic [WIDTH-1:0]     calc_res;

    // Stall chain: S2 frees up when empty or being popped; S1 follows it.
    always_comb begin
        s2_adv   = !s2_v || out_ready;
        in_ready = !s1_v || s2_adv;
        take_in  = in_valid && in_ready;
        pop      = s2_v && out_ready;
    end

    // Full-precision signed arithmetic on sign-extended S1 operands.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        full     = '0;
        is_logic = 1'b0;
        ext_a    = {{3{s1_a[WIDTH-1]}}, s1_a};
        ext_b    = {{3{s1_b[WIDTH-1]}}, s1_b};
        case (s1_op)
            OP_SHL_ADD: full = (ext_a <<< 1) + ext_b;
            OP_A_3B:    full = ext_a + ext_b + (ext_b <<< 1);
            OP_NEG_B:   full = -ext_b;
            OP_ABS_A:   full = ext_a[XW-1] ? -ext_a : ext_a;
            OP_SUB:     full = ext_a - ext_b;
            OP_AND:     begin full = ext_a & ext_b; is_logic = 1'b1; end
            OP_OR:      begin full = ext_a | ext_b; is_logic = 1'b1; end
            OP_XOR:     begin full = ext_a ^ ext_b; is_logic = 1'b1; end
            default:    full = '0;
        endcase
    end

    // Range check and final result selection (wrap or clamp).
    always_comb begin
        // In range iff the guard bits and the result sign bit all agree.
        fits     = (&full[XW-1:WIDTH-1]) || !(|full[XW-1:WIDTH-1]);
        calc_ovf = !fits && !is_logic;
`ifdef ALU_SAT_EN
        if (calc_ovf)
            calc_res = full[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
        else
            calc_res = full[WIDTH-1:0];
`else
        calc_res = full[WIDTH-1:0];
`endif
    end

    // S1 register: loads on an input handshake, empties when it drains into S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_op <= '0;
        end else if (in_ready) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            s1_v <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op;
            end
        end
    end

    // S2 register: advances when empty or popped; holds result stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v      <= 1'b0;
            s2_result <= '0;
            s2_ovf    <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_result <= calc_res;
                s2_ovf    <= calc_ovf;
            end
        end
    end

    // Completed-operation counter, one step per output handshake, free-running wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (pop)
            cnt <= cnt + CNT_W'(1);
    end

    assign out_valid = s2_v;
    assign result    = s2_result;
    assign ovf       = s2_ovf;
    assign ops_done  = cnt;

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe : directed self-checking bench for alu_pipe (WIDTH=6, CNT_W=8).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] result;
    logic       ovf;
    logic [7:0] ops_done;

    int errors = 0;
    int checks = 0;
    int exp_ops = 0;

    alu_pipe #(.WIDTH(6), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One isolated beat: accept, check 2-cycle latency, check result/ovf, popped next edge.
    task automatic single(input string tag, input int av, input int bv, input logic [2:0] opv,
                          input int er, input logic eo);
        @(negedge clk);
        a = av[5:0]; b = bv[5:0]; op = opv; in_valid = 1'b1;
        #1 chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_lat2_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_result"}, {26'b0, result}, {26'b0, er[5:0]});
        chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
        exp_ops++;
    endtask

    initial begin
        int exp4[4];
        int acc;
        int pops;
        int low_rdy;
        int cyc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;

        // Reset state
        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result",    {26'b0, result},    32'd0);
        chk("rst_ovf",       {31'b0, ovf},       32'd0);
        chk("rst_ops_done",  {24'b0, ops_done},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Arithmetic ops and overflow corners
        single("shl_add_15_5", 15, 5, 3'b000, SAT ? 31 : -29, 1'b1);
        single("a3b_12_8",     12, 8, 3'b001, SAT ? 31 : -28, 1'b1);
        single("negb_m4",      0, -4, 3'b010, 4, 1'b0);
        single("absa_m9",     -9, 0,  3'b011, 9, 1'b0);
        single("absa_min",   -32, 0,  3'b011, SAT ? 31 : -32, 1'b1);
        single("sub_min_1",  -32, 1,  3'b100, SAT ? -32 : 31, 1'b1);
        single("sub_3_5",      3, 5,  3'b100, -2, 1'b0);
        single("negb_min",     0, -32, 3'b010, SAT ? 31 : -32, 1'b1);
        @(negedge clk);
        chk("ops_after_singles", {24'b0, ops_done}, exp_ops);

        // Back-to-back stream with 3 cycles of backpressure
        exp4 = '{-1, 4, 10, -10};
        acc = 0; pops = 0; low_rdy = 0;
        for (cyc = 0; cyc < 12; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            case (acc)
                0: begin a = 6'd1;  b = 6'd2;          in_valid = 1'b1; end
                1: begin a = 6'd5;  b = 6'd1;          in_valid = 1'b1; end
                2: begin a = 6'd7;  b = 6'(-3);        in_valid = 1'b1; end
                3: begin a = 6'(-8); b = 6'd2;         in_valid = 1'b1; end
                default: in_valid = 1'b0;
            endcase
            op = 3'b100;
            #1;
            if (cyc == 2) chk("bp_in_ready_drop", {31'b0, in_ready}, 32'd0);
            if (!in_ready) low_rdy++;
            if (in_valid && in_ready) acc++;
            if (out_valid) begin
                if (pops < 4) begin
                    if (out_ready) begin
                        chk($sformatf("bp_order_%0d", pops), {26'b0, result}, {26'b0, exp4[pops][5:0]});
                        pops++;
                    end else begin
                        chk($sformatf("bp_hold_%0d", cyc), {26'b0, result}, {26'b0, exp4[pops][5:0]});
                    end
                end else begin
                    chk("bp_extra_beat", {31'b0, out_valid}, 32'd0);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        exp_ops += 4;
        chk("bp_pops",       pops,    32'd4);
        chk("bp_accepts",    acc,     32'd4);
        chk("bp_ready_low",  low_rdy, 32'd3);
        chk("bp_ops_done",   {24'b0, ops_done}, exp_ops);

        // Reset with both stages full
        out_ready = 1'b0;
        a = 6'd3; b = 6'd4; op = 3'b000; in_valid = 1'b1;
        @(negedge clk);
        a = 6'd9; b = 6'd1; op = 3'b100;
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_out_valid", {31'b0, out_valid}, 32'd1);
        chk("full_in_ready",  {31'b0, in_ready},  32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_ops_done",  {24'b0, ops_done},  32'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        exp_ops = 0;
        single("post_rst_a3b", 2, -3, 3'b001, -7, 1'b0);

        // Logic ops
        single("and_2a_0f", 42, 15, 3'b101, 10, 1'b0);
        single("or_2a_0f",  42, 15, 3'b110, 47, 1'b0);
        single("xor_2a_0f", 42, 15, 3'b111, 37, 1'b0);
        @(negedge clk);
        chk("ops_before_wrap", {24'b0, ops_done}, exp_ops);

        // Stream 252 more beats: 4 + 252 = 256 handshakes -> counter wraps to 0
        acc = 0; pops = 0;
        a = 6'h2A; b = 6'h0F; op = 3'b101;
        for (cyc = 0; cyc < 400 && pops < 252; cyc++) begin
            in_valid = (acc < 252);
            #1;
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) begin
                if (pops == 0 || pops == 251)
                    chk($sformatf("wrap_and_%0d", pops), {26'b0, result}, 32'h0A);
                pops++;
                if (pops == 251) begin
                    @(negedge clk);
                    chk("ops_at_255", {24'b0, ops_done}, 32'd255);
                    continue;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("wrap_pops", pops, 32'd252);
        @(negedge clk);
        chk("ops_wrapped", {24'b0, ops_done}, 32'd0);
        chk("idle_out_valid", {31'b0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
